calc_result_sel: RTL and testbench

//   Registered result selector for the calculator datapath. Launches one operation per start pulse.

---
 rtl/calc_result_sel.sv | 140 ++++++++++++++
 tb/tb_calc_result_sel.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/calc_result_sel.sv
// Registered result selector: launches one operation per start, waits for the selected unit,
// formats and holds its result behind a valid/ack handshake, with a watchdog. Option: CALC_SAT_EN.
// States: S_IDLE idle | S_WAIT awaiting selected done | S_HOLD result held until ack
module calc_result_sel #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [1:0]         i_op,
  input  logic [WIDTH:0]     i_sum,
  input  logic               i_sum_ovf,
  input  logic               i_sum_done,
  input  logic [2*WIDTH-1:0] i_prod,
  input  logic               i_prod_done,
  input  logic               i_out_ack,
  output logic [2*WIDTH-1:0] o_out,
  output logic               o_ovf_out,
  output logic               o_out_valid,
  output logic               o_busy,
  output logic               o_timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_op_q;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_out;
  logic               r_ovf_out;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_timeout_err;

  logic               w_done;
  logic               w_launch;
  logic               w_capture;
  logic               w_timeout;
  logic [2*WIDTH-1:0] w_fmt;
  logic               w_fmt_ovf;
  logic               w_unused_op;

  // Only op_q[1] steers the datapath; add and sub share the sum path.
  assign w_unused_op = r_op_q[0];
  assign w_done      = r_op_q[1] ? i_prod_done : i_sum_done;

  always_comb begin
    w_fmt     = '0;
    w_fmt_ovf = 1'b0;
    if (r_op_q[1]) begin
      w_fmt = i_prod;
    end else begin
      w_fmt[WIDTH:0] = i_sum;
`ifdef CALC_SAT_EN
      if (i_sum_ovf) w_fmt[WIDTH:0] = '1;
`endif
      w_fmt[2*WIDTH-1] = i_sum_ovf;
      w_fmt_ovf        = i_sum_ovf;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_launch    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A done arriving on the last allowed cycle still beats the watchdog.
        if (w_done) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_out_ack) begin
          if (i_start) begin
            w_launch    = 1'b1;
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_op_q        <= '0;
      r_cnt         <= '0;
      r_out         <= '0;
      r_ovf_out     <= 1'b0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt == S_WAIT);
      r_out_valid <= (w_state_nxt == S_HOLD);
      if (w_launch) begin
        r_op_q <= i_op;
        r_cnt  <= '0;
      end else if (r_state == S_WAIT && !w_capture && !w_timeout) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_capture) begin
        r_out         <= w_fmt;
        r_ovf_out     <= w_fmt_ovf;
        r_timeout_err <= 1'b0;
      end else if (w_timeout) begin
        r_out         <= '0;
        r_ovf_out     <= 1'b0;
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign o_out         = r_out;
  assign o_ovf_out     = r_ovf_out;
  assign o_out_valid   = r_out_valid;
  assign o_busy        = r_busy;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_calc_result_sel.sv
// Self-checking bench for calc_result_sel: directed scenarios plus randomized operations
// compared against a transaction-level reference model.
module tb_calc_result_sel;
  localparam int W  = 4;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [1:0]     op;
  logic [W:0]     sum;
  logic           sum_ovf;
  logic           sum_done;
  logic [2*W-1:0] prod;
  logic           prod_done;
  logic           out_ack;
  logic [2*W-1:0] out;
  logic           ovf_out;
  logic           out_valid;
  logic           busy;
  logic           timeout_err;

  int total = 0;
  int bad   = 0;

  logic [2*W-1:0] exp_out;
  logic           exp_ovf;
  logic           exp_tmo;

  always #5 clk = ~clk;

  calc_result_sel #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
    .i_sum(sum), .i_sum_ovf(sum_ovf), .i_sum_done(sum_done),
    .i_prod(prod), .i_prod_done(prod_done), .i_out_ack(out_ack),
    .o_out(out), .o_ovf_out(ovf_out), .o_out_valid(out_valid),
    .o_busy(busy), .o_timeout_err(timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: result word from the operation and the unit outputs, by plain arithmetic.
  function automatic logic [2*W-1:0] model_out(input logic [1:0] o, input int s, input bit ov, input int p);
    int r;
    if (o[1]) r = p;
    else begin
      r = s;
`ifdef CALC_SAT_EN
      if (ov) r = (1 << (W + 1)) - 1;
`endif
      if (ov) r = r + (1 << (2 * W - 1));
    end
    return r[2*W-1:0];
  endfunction

  task automatic check_result(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'(1));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_out"}, 32'(out), 32'(exp_out));
    check({tag, "_ovf"}, 32'(ovf_out), 32'(exp_ovf));
    check({tag, "_tmo"}, 32'(timeout_err), 32'(exp_tmo));
  endtask

  // dly: WAIT-cycle index on which the selected done pulses (<0 or >=TO means never in time).
  task automatic do_op(input string tag, input logic [1:0] o, input bit via_ack, input int dly,
                       input logic [W:0] s, input bit ov, input logic [2*W-1:0] p, input bit noise);
    int  n_wait;
    bit  got;
    op = o; start = 1'b1; out_ack = via_ack;
    step();
    start = 1'b0; out_ack = 1'b0; op = 2'($urandom);
    got    = (dly >= 0 && dly < TO);
    n_wait = got ? dly + 1 : TO;
    for (int k = 0; k < n_wait; k++) begin
      check({tag, "_busy_wait"}, 32'(busy), 32'(1));
      check({tag, "_valid_wait"}, 32'(out_valid), 32'(0));
      sum = (W+1)'($urandom); sum_ovf = 1'($urandom); prod = (2*W)'($urandom);
      start = noise ? 1'($urandom) : 1'b0;
      if (k == dly) begin
        sum = s; sum_ovf = ov; prod = p;
      end
      if (o[1]) begin
        prod_done = (k == dly);
        sum_done  = noise ? 1'($urandom) : 1'b0;
      end else begin
        sum_done  = (k == dly);
        prod_done = noise ? 1'($urandom) : 1'b0;
      end
      step();
      sum_done = 1'b0; prod_done = 1'b0; start = 1'b0;
    end
    if (got) begin
      exp_out = model_out(o, int'(s), ov, int'(p));
      exp_ovf = o[1] ? 1'b0 : ov;
      exp_tmo = 1'b0;
    end else begin
      exp_out = '0; exp_ovf = 1'b0; exp_tmo = 1'b1;
    end
    check_result(tag);
  endtask

  // Sit in HOLD for n cycles (start without ack must be ignored), then optionally ack to IDLE.
  task automatic hold(input string tag, input int n, input bit release_it);
    for (int k = 0; k < n; k++) begin
      start = 1'($urandom); op = 2'($urandom); out_ack = 1'b0;
      sum_done = 1'($urandom); prod_done = 1'($urandom);
      step();
      start = 1'b0; sum_done = 1'b0; prod_done = 1'b0;
      check_result({tag, "_hold"});
    end
    if (release_it) begin
      out_ack = 1'b1;
      step();
      out_ack = 1'b0;
      check({tag, "_ack_valid"}, 32'(out_valid), 32'(0));
      check({tag, "_ack_busy"}, 32'(busy), 32'(0));
      check({tag, "_ack_keep"}, 32'(out), 32'(exp_out));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; sum = '0; sum_ovf = 1'b0; sum_done = 1'b0;
    prod = '0; prod_done = 1'b0; out_ack = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_out", 32'(out), 32'(0));
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_tmo", 32'(timeout_err), 32'(0));
    sum_done = 1'b1; prod_done = 1'b1;
    step();
    sum_done = 1'b0; prod_done = 1'b0;
    check("idle_busy", 32'(busy), 32'(0));
    check("idle_valid", 32'(out_valid), 32'(0));

    do_op("add", 2'b00, 1'b0, 2, 5'h0D, 1'b0, 8'h00, 1'b0);
    check("add_out_0d", 32'(out), 32'h0D);
    hold("add", 3, 1'b1);

    do_op("mul", 2'b10, 1'b0, 1, 5'h00, 1'b0, 8'hE1, 1'b1);
    check("mul_out_e1", 32'(out), 32'hE1);
    hold("mul", 2, 1'b1);

    do_op("sub", 2'b01, 1'b0, 0, 5'h13, 1'b1, 8'h00, 1'b0);
`ifdef CALC_SAT_EN
    check("sub_out_sat", 32'(out), 32'h9F);
`else
    check("sub_out_raw", 32'(out), 32'h93);
`endif
    hold("sub", 1, 1'b1);

    do_op("tmo", 2'b11, 1'b0, -1, 5'h00, 1'b0, 8'h00, 1'b1);
    check("tmo_flag", 32'(timeout_err), 32'(1));
    hold("tmo", 2, 1'b1);
    do_op("after_tmo", 2'b00, 1'b0, 4, 5'h07, 1'b0, 8'h00, 1'b0);
    check("tmo_cleared", 32'(timeout_err), 32'(0));

    // ack and start together in HOLD relaunch straight into WAIT
    do_op("ackstart", 2'b00, 1'b1, 1, 5'h1A, 1'b0, 8'h00, 1'b0);
    hold("ackstart", 1, 1'b1);

    do_op("edge_last", 2'b10, 1'b0, TO - 1, 5'h00, 1'b0, 8'h5C, 1'b0);
    hold("edge_last", 0, 1'b1);
    do_op("edge_late", 2'b00, 1'b0, TO, 5'h0F, 1'b1, 8'h00, 1'b0);
    hold("edge_late", 0, 1'b1);

    // reset held for two cycles in the middle of WAIT
    op = 2'b11; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("midrst_out", 32'(out), 32'(0));
    check("midrst_valid", 32'(out_valid), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_tmo", 32'(timeout_err), 32'(0));
    step();
    check("midrst_idle", 32'(busy), 32'(0));

    for (int i = 0; i < 40; i++) begin
      int d;
      d = ($urandom_range(0, 7) == 0) ? TO + 2 : int'($urandom_range(0, TO - 1));
      do_op("rnd", 2'($urandom), 1'b0, d, (W+1)'($urandom), 1'($urandom), (2*W)'($urandom), 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        d = int'($urandom_range(0, 5));
        do_op("rnd_chain", 2'($urandom), 1'b1, d, (W+1)'($urandom), 1'($urandom), (2*W)'($urandom), 1'b1);
      end
      hold("rnd", int'($urandom_range(0, 2)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
